tile_map_writer: RTL and testbench
==================================

TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 The block SHALL use reset resetN, asynchronous, active-low; clock clk.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- wr_req  in  1  tile write request, held until wr_ack
- wr_row  in  3  target row, 0..4
- wr_col  in  3  target column, 0..6
- wr_data  in  1  1 = set platform tile, 0 = clear
- wr_ack  out  1  one-cycle write acknowledge
- wr_err  out  1  one-cycle pulse with wr_ack when coordinates are out of range
- scroll_req  in  1  one-cycle pulse requesting a one-row scroll
- new_row  in  7  bits for the new top row, sampled with scroll_req
- busy  out  1  write or scroll in progress
- pixelX  in  11  current VGA pixel X
- pixelY  in  11  current VGA pixel Y
- tile_hit  out  1  displayed map bit at (pixelX, pixelY)

Function
REQ-003 The map SHALL be 5 rows x 7 columns of 90x90-pixel tiles, held in two copies: working map and display map.
REQ-004 Bit index SHALL equal column number; row index SHALL equal pixelY/90.
REQ-005 The FSM SHALL have states IDLE, WRITE and SHIFT.
REQ-006 IDLE: if scroll_req=1, the FSM SHALL latch new_row and go to SHIFT; else if wr_req=1 and wr_ack=0, it SHALL go to WRITE.
REQ-007 Scroll SHALL win over a simultaneous write; the write SHALL stay pending while wr_req is held and SHALL be served after SHIFT completes.
REQ-008 WRITE (one cycle): the FSM SHALL update the addressed bit in both copies, assert wr_ack for exactly that cycle, and return to IDLE.
REQ-009 If wr_row>4 or wr_col>6, WRITE SHALL leave the map unchanged and assert wr_err together with wr_ack.
REQ-010 The requester SHALL drop wr_req in the cycle after wr_ack; wr_req sampled high in the IDLE cycle right after wr_ack SHALL be ignored.
REQ-011 SHIFT SHALL last exactly 5 cycles. Cycles 1-4 SHALL copy working row r-1 into row r, for r = 4, 3, 2, 1. Cycle 5 SHALL load row 0 with the latched new_row, copy the working map into the display map, and return to IDLE.
REQ-012 scroll_req and wr_req arriving during SHIFT or WRITE SHALL NOT be accepted; a scroll_req pulse arriving then SHALL be lost.
REQ-013 busy SHALL be 1 in every WRITE and SHIFT cycle and 0 in IDLE.
REQ-014 tile_hit SHALL be registered, with 1-cycle latency from pixelX/pixelY. It SHALL read the display map only.
REQ-015 tile_hit SHALL be 0 for pixelX>=630 or pixelY>=450.
REQ-016 The tile index SHALL be computed with compare chains against multiples of 90; no divider.

Reset
REQ-017 On resetN=0, the block SHALL immediately set both map copies to the default pattern: row 4 = 7'b1111111, row 3 = 7'b0000001, rows 0-2 = 0.
REQ-018 On resetN=0, the FSM SHALL go to IDLE and tile_hit, wr_ack, wr_err and busy SHALL be 0.
REQ-019 A reset during SHIFT or WRITE SHALL abort the operation with no partial update visible after reset.

Configuration
REQ-020 Macro TILE_MAP_SCROLL_EN: when defined, the SHIFT state, scroll_req and new_row SHALL be functional.
REQ-021 When TILE_MAP_SCROLL_EN is undefined, SHIFT SHALL be absent, scroll_req and new_row SHALL be ignored, and busy SHALL be asserted only in WRITE.

Structure
REQ-022 Package tile_map_pkg SHALL hold: ROWS=5, COLS=7, TILE_W=90, TILE_H=90, the default map constant, and the FSM state enum.
REQ-023 Sub-module tile_index_calc SHALL map pixelX/pixelY to row, column and an in_range flag (combinational); tile_map_writer SHALL register its result.

Verification
REQ-024 Reset, then sweep pixels: (0,400) -> tile_hit=1; (100,300) -> 0; (10,300) -> 1; (700,400) -> 0. Each response SHALL appear one cycle after the pixel is applied.
REQ-025 wr_req with row=0, col=3, data=1 -> wr_ack for one cycle, wr_err=0; pixel (300,50) -> tile_hit=1.
REQ-026 wr_req with row=5, col=2 -> wr_ack=1 and wr_err=1 in the same cycle; map unchanged.
REQ-027 scroll_req with new_row=7'b1010101 in the same cycle as wr_req -> busy for 5 cycles; then row 4 = 7'b0000001, row 0 = 7'b1010101; the write then completes with wr_ack. During the scroll, tile_hit SHALL still show the pre-scroll map.
REQ-028 Assert resetN=0 in the 3rd SHIFT cycle -> default map, IDLE, busy=0.
REQ-029 With TILE_MAP_SCROLL_EN undefined, scroll_req -> busy stays 0 and the map is unchanged.

Source files
------------

// File: rtl/tile_map_pkg.sv
// Shared geometry, default map pattern, FSM state type and coordinate check
// for the tile map writer.
package tile_map_pkg;

    localparam int ROWS   = 5;
    localparam int COLS   = 7;
    localparam int TILE_W = 90;
    localparam int TILE_H = 90;

    // Row r of the map is element [r]; bit c of a row is column c.
    typedef logic [ROWS-1:0][COLS-1:0] tile_map_t;

    localparam tile_map_t DEFAULT_MAP = {7'b1111111, 7'b0000001, 7'b0000000,
                                         7'b0000000, 7'b0000000};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic coord_bad(input logic [2:0] row, input logic [2:0] col);
        return (row > 3'(ROWS - 1)) || (col > 3'(COLS - 1));
    endfunction

endpackage

// File: rtl/tile_map_writer_index.sv
// tile_index_calc: combinational pixel-to-tile mapping using compare chains
// against tile-edge multiples (no divider).
module tile_index_calc
    import tile_map_pkg::*;
(
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [2:0]  tile_row,
    output logic [2:0]  tile_col,
    output logic        in_range
);

    // Column select from the horizontal tile edges
    always_comb begin
        tile_col = 3'd7;
        if      (pixelX < 11'(1 * TILE_W)) tile_col = 3'd0;
        else if (pixelX < 11'(2 * TILE_W)) tile_col = 3'd1;
        else if (pixelX < 11'(3 * TILE_W)) tile_col = 3'd2;
        else if (pixelX < 11'(4 * TILE_W)) tile_col = 3'd3;
        else if (pixelX < 11'(5 * TILE_W)) tile_col = 3'd4;
        else if (pixelX < 11'(6 * TILE_W)) tile_col = 3'd5;
        else if (pixelX < 11'(7 * TILE_W)) tile_col = 3'd6;
        else                               tile_col = 3'd7;
    end

    // Row select from the vertical tile edges
    always_comb begin
        tile_row = 3'd5;
        if      (pixelY < 11'(1 * TILE_H)) tile_row = 3'd0;
        else if (pixelY < 11'(2 * TILE_H)) tile_row = 3'd1;
        else if (pixelY < 11'(3 * TILE_H)) tile_row = 3'd2;
        else if (pixelY < 11'(4 * TILE_H)) tile_row = 3'd3;
        else if (pixelY < 11'(5 * TILE_H)) tile_row = 3'd4;
        else                               tile_row = 3'd5;
    end

    assign in_range = (pixelX < 11'(COLS * TILE_W)) && (pixelY < 11'(ROWS * TILE_H));

endmodule

// File: rtl/tile_map_writer.sv
// Tile map writer: 5x7 platform map (working + display copies), single-cycle
// tile writes and a registered pixel lookup. Scrolling exists only with TILE_MAP_SCROLL_EN.
module tile_map_writer
    import tile_map_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        wr_req,
    input  logic [2:0]  wr_row,
    input  logic [2:0]  wr_col,
    input  logic        wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    input  logic        scroll_req,
    input  logic [6:0]  new_row,
    output logic        busy,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        tile_hit
);

    state_t     state_r;
    tile_map_t  work_map_r;
    tile_map_t  disp_map_r;
    logic [2:0] lat_row_r;
    logic [2:0] lat_col_r;
    logic       lat_data_r;
    logic       wr_ack_r;
    logic       wr_err_r;
    logic       busy_r;
    logic       skip_r;
    logic       tile_hit_r;
    logic [2:0] pix_row_s;
    logic [2:0] pix_col_s;
    logic       pix_in_range_s;

`ifdef TILE_MAP_SCROLL_EN
    logic [6:0] new_row_r;
    logic [2:0] shift_cnt_r;
`else
    logic       unused_scroll_s;
    assign unused_scroll_s = ^{scroll_req, new_row, work_map_r};
`endif

    tile_index_calc u_index (
        .pixelX   (pixelX),
        .pixelY   (pixelY),
        .tile_row (pix_row_s),
        .tile_col (pix_col_s),
        .in_range (pix_in_range_s)
    );

    // Control FSM together with both map copies and the handshake outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            work_map_r  <= DEFAULT_MAP;
            disp_map_r  <= DEFAULT_MAP;
            lat_row_r   <= 3'd0;
            lat_col_r   <= 3'd0;
            lat_data_r  <= 1'b0;
            wr_ack_r    <= 1'b0;
            wr_err_r    <= 1'b0;
            busy_r      <= 1'b0;
            skip_r      <= 1'b0;
`ifdef TILE_MAP_SCROLL_EN
            new_row_r   <= 7'd0;
            shift_cnt_r <= 3'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    // skip_r masks the still-held request in the cycle after an ack
                    skip_r <= 1'b0;
`ifdef TILE_MAP_SCROLL_EN
                    new_row_r   <= new_row;
                    shift_cnt_r <= 3'd0;
                    if (scroll_req) begin
                        wr_ack_r <= 1'b0;
                        wr_err_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end else
`endif
                    if (wr_req && !skip_r) begin
                        lat_row_r  <= wr_row;
                        lat_col_r  <= wr_col;
                        lat_data_r <= wr_data;
                        wr_ack_r   <= 1'b1;
                        wr_err_r   <= coord_bad(wr_row, wr_col);
                        busy_r     <= 1'b1;
                        state_r    <= WRITE;
                    end else begin
                        wr_ack_r <= 1'b0;
                        wr_err_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                WRITE: begin
                    if (!wr_err_r) begin
                        work_map_r[lat_row_r][lat_col_r] <= lat_data_r;
                        disp_map_r[lat_row_r][lat_col_r] <= lat_data_r;
                    end
                    wr_ack_r <= 1'b0;
                    wr_err_r <= 1'b0;
                    busy_r   <= 1'b0;
                    skip_r   <= 1'b1;
                    state_r  <= IDLE;
                end
`ifdef TILE_MAP_SCROLL_EN
                SHIFT: begin
                    if (shift_cnt_r == 3'd4) begin
                        work_map_r[0] <= new_row_r;
                        disp_map_r    <= {work_map_r[4:1], new_row_r};
                        shift_cnt_r   <= 3'd0;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        work_map_r[3'd4 - shift_cnt_r] <= work_map_r[3'd3 - shift_cnt_r];
                        shift_cnt_r <= shift_cnt_r + 3'd1;
                        busy_r      <= 1'b1;
                        state_r     <= SHIFT;
                    end
                end
`endif
                default: begin
                    wr_ack_r <= 1'b0;
                    wr_err_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Pixel lookup against the display copy, one cycle behind pixelX/pixelY
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tile_hit_r <= 1'b0;
        end else begin
            tile_hit_r <= pix_in_range_s ? disp_map_r[pix_row_s][pix_col_s] : 1'b0;
        end
    end

    assign wr_ack   = wr_ack_r;
    assign wr_err   = wr_err_r;
    assign busy     = busy_r;
    assign tile_hit = tile_hit_r;

endmodule

// File: tb/tb_tile_map_writer.sv
// Scoreboard bench for tile_map_writer: randomized writes/scrolls/pixel probes
// checked against a row/column array model of the displayed map.
module tb_tile_map_writer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        wr_req;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic        wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        scroll_req;
    logic [6:0]  new_row;
    logic        busy;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        tile_hit;

    tile_map_writer dut (
        .clk        (clk),
        .resetN     (resetN),
        .wr_req     (wr_req),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .scroll_req (scroll_req),
        .new_row    (new_row),
        .busy       (busy),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .tile_hit   (tile_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
        bit exp;
    } probe_t;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    bit     model_map [5][7];
    probe_t pix_q [$];
    bit     ack_q [$];
    probe_t mon_p;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_default();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++)
                model_map[r][c] = (r == 4) || (r == 3 && c == 0);
    endfunction

    function automatic void model_scroll(input logic [6:0] nr);
        for (int r = 4; r >= 1; r--)
            for (int c = 0; c < 7; c++)
                model_map[r][c] = model_map[r-1][c];
        for (int c = 0; c < 7; c++)
            model_map[0][c] = nr[c];
    endfunction

    function automatic bit model_hit(input int x, input int y);
        if (x >= 630 || y >= 450) return 1'b0;
        return model_map[y / 90][x / 90];
    endfunction

    // Monitor: pops expected acks and pixel responses as the DUT presents them
    always @(negedge clk) begin
        if (resetN) begin
            if (wr_ack) begin
                if (ack_q.size() == 0) chk("unexpected_ack", int'(wr_ack), 0);
                else                   chk("wr_err", int'(wr_err), int'(ack_q.pop_front()));
            end else if (wr_err) begin
                chk("err_without_ack", int'(wr_err), 0);
            end
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                mon_p = pix_q.pop_front();
                chk($sformatf("tile_hit(%0d,%0d)", mon_p.x, mon_p.y), int'(tile_hit), int'(mon_p.exp));
            end
        end
    end

    task automatic probe(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        pix_q.push_back('{cyc + 1, x, y, model_hit(x, y)});
    endtask

    task automatic probe_at(input int x, input int y);
        @(negedge clk);
        probe(x, y);
    endtask

    task automatic rand_probe();
        probe($urandom_range(0, 700), $urandom_range(0, 520));
    endtask

    task automatic check_full_map();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++)
                probe_at(c * 90 + 45, r * 90 + 45);
        @(negedge clk);
    endtask

    // Caller positions this at a negedge; reset takes effect immediately
    task automatic apply_reset();
        resetN     = 1'b0;
        wr_req     = 1'b0;
        scroll_req = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_tile_hit", int'(tile_hit), 0);
        pix_q.delete();
        ack_q.delete();
        model_default();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic finish_write(input logic [2:0] r, input logic [2:0] c, input logic d);
        int n;
        bit is_bad;
        is_bad = (r > 3'd4) || (c > 3'd6);
        n = 0;
        while (wr_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (wr_ack !== 1'b1) begin
            chk("ack_timeout", int'(wr_ack), 1);
            wr_req = 1'b0;
            ack_q.delete();
            return;
        end
        chk("busy_write", int'(busy), 1);
        if (!is_bad) model_map[r][c] = d;
        @(negedge clk);
        chk("busy_idle_after_write", int'(busy), 0);
        chk("ack_one_cycle", int'(wr_ack), 0);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] r, input logic [2:0] c, input logic d);
        @(negedge clk);
        wr_row  = r;
        wr_col  = c;
        wr_data = d;
        wr_req  = 1'b1;
        ack_q.push_back((r > 3'd4) || (c > 3'd6));
        finish_write(r, c, d);
    endtask

`ifdef TILE_MAP_SCROLL_EN
    task automatic do_scroll(input logic [6:0] nr, input bit with_wr,
                             input logic [2:0] r, input logic [2:0] c, input logic d);
        @(negedge clk);
        scroll_req = 1'b1;
        new_row    = nr;
        if (with_wr) begin
            wr_row  = r;
            wr_col  = c;
            wr_data = d;
            wr_req  = 1'b1;
            ack_q.push_back((r > 3'd4) || (c > 3'd6));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            scroll_req = (k == 4);
            new_row    = 7'($urandom);
            chk("busy_shift", int'(busy), 1);
            rand_probe();
        end
        @(negedge clk);
        scroll_req = 1'b0;
        chk("busy_after_shift", int'(busy), 0);
        model_scroll(nr);
        if (with_wr) finish_write(r, c, d);
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        scroll_req = 1'b1;
        new_row    = 7'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            scroll_req = 1'b0;
            chk("busy_before_abort", int'(busy), 1);
        end
        apply_reset();
        @(negedge clk);
        chk("busy_after_abort", int'(busy), 0);
    endtask
`endif

    initial begin
        resetN     = 1'b0;
        wr_req     = 1'b0;
        wr_row     = 3'd0;
        wr_col     = 3'd0;
        wr_data    = 1'b0;
        scroll_req = 1'b0;
        new_row    = 7'd0;
        pixelX     = 11'd0;
        pixelY     = 11'd0;
        @(negedge clk);
        apply_reset();

        probe_at(0, 400);
        probe_at(100, 300);
        probe_at(10, 300);
        probe_at(700, 400);
        probe_at(629, 449);
        probe_at(630, 400);
        probe_at(0, 450);
        probe_at(89, 89);
        probe_at(90, 359);
        @(negedge clk);

        do_write(3'd0, 3'd3, 1'b1);
        probe_at(300, 50);
        do_write(3'd5, 3'd2, 1'b1);
        do_write(3'd4, 3'd7, 1'b0);
        do_write(3'd4, 3'd6, 1'b0);
        check_full_map();

`ifdef TILE_MAP_SCROLL_EN
        do_scroll(7'b1010101, 1'b1, 3'd2, 3'd4, 1'b1);
        check_full_map();
        reset_mid_shift();
        check_full_map();
        do_scroll(7'b0110011, 1'b0, 3'd0, 3'd0, 1'b0);
        check_full_map();
`else
        @(negedge clk);
        scroll_req = 1'b1;
        new_row    = 7'b1010101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            scroll_req = 1'b0;
            chk("busy_no_scroll", int'(busy), 0);
        end
        check_full_map();
`endif

        for (int i = 0; i < 30; i++) begin
            int op;
            op = $urandom_range(0, 3);
`ifdef TILE_MAP_SCROLL_EN
            if (op == 0)
                do_scroll(7'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else
`endif
            do_write(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                rand_probe();
            end
        end
        check_full_map();
        repeat (2) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("pix_queue_drained", pix_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
